// File: rtl/fft_input_loader.sv
// Packs natural-order samples into RADIX-wide rows, one lane per memory bank, then pulses fft_start.
// Optional: define FFT_LOADER_MODRED_EN to reduce each sample modulo P = 2^64 - 2^32 + 1 on capture.
module fft_input_loader #(
   parameter int DATA_WIDTH   = 64,
   parameter int RADIX        = 16,
   parameter int TOTAL_POINTS = 65536
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start_load,
   input  logic                                     in_valid,
   input  logic [DATA_WIDTH-1:0]                    in_data,
   output logic                                     in_ready,
   output logic                                     row_valid,
   output logic [$clog2(TOTAL_POINTS/RADIX)-1:0]    row_addr,
   output logic [RADIX*DATA_WIDTH-1:0]              row_data,
   output logic                                     load_done,
   output logic                                     fft_start
);
   localparam int ROWS   = TOTAL_POINTS / RADIX;
   localparam int LANE_W = $clog2(RADIX);
   localparam int ROW_W  = $clog2(ROWS);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RADIX - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                             state_q;
   logic [LANE_W-1:0]                  lane_q;
   logic [ROW_W-1:0]                   row_q;
   logic                               in_ready_q;
   logic                               row_valid_q;
   logic                               load_done_q;
   logic                               fft_start_q;
   logic [ROW_W-1:0]                   row_addr_q;
   logic [RADIX*DATA_WIDTH-1:0]        row_data_q;
   logic [RADIX*DATA_WIDTH-1:0]        row_data_d;
   logic [RADIX-1:0][DATA_WIDTH-1:0]   lane_buf_q;
   logic [DATA_WIDTH-1:0]              sample_s;
   logic                               handshake_s;

`ifdef FFT_LOADER_MODRED_EN
   localparam logic [DATA_WIDTH-1:0] MOD_P = DATA_WIDTH'(64'hFFFF_FFFF_0000_0001);

   function automatic logic [DATA_WIDTH-1:0] mod_reduce(input logic [DATA_WIDTH-1:0] x);
      if (x >= MOD_P) begin
         return x - MOD_P;
      end else begin
         return x;
      end
   endfunction

   assign sample_s = mod_reduce(in_data);
`else
   assign sample_s = in_data;
`endif

   assign handshake_s = in_valid & in_ready_q;

   // The last lane bypasses the buffer so a row can leave on the cycle after its 16th sample.
   always_comb begin
      row_data_d = lane_buf_q;
      row_data_d[(RADIX-1)*DATA_WIDTH +: DATA_WIDTH] = sample_s;
   end

   // No reset here: every lane is rewritten before a row is emitted.
   always_ff @(posedge clk) begin
      if (handshake_s) begin
         lane_buf_q[lane_q] <= sample_s;
      end
   end

   // Load sequencer with registered handshake and strobe outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         lane_q      <= '0;
         row_q       <= '0;
         in_ready_q  <= 1'b0;
         row_valid_q <= 1'b0;
         load_done_q <= 1'b0;
         fft_start_q <= 1'b0;
         row_addr_q  <= '0;
         row_data_q  <= '0;
      end else begin
         row_valid_q <= 1'b0;
         fft_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_load) begin
                  lane_q     <= '0;
                  row_q      <= '0;
                  in_ready_q <= 1'b1;
                  state_q    <= LOAD;
               end
            end
            LOAD: begin
               if (handshake_s) begin
                  lane_q <= lane_q + LANE_W'(1);
                  if (lane_q == LAST_LANE) begin
                     row_valid_q <= 1'b1;
                     row_addr_q  <= row_q;
                     row_data_q  <= row_data_d;
                     // Row counter only wraps on the way out to DONE.
                     if (row_q == LAST_ROW) begin
                        row_q       <= '0;
                        in_ready_q  <= 1'b0;
                        load_done_q <= 1'b1;
                        fft_start_q <= 1'b1;
                        state_q     <= DONE;
                     end else begin
                        row_q <= row_q + ROW_W'(1);
                     end
                  end
               end
            end
            DONE: begin
               if (start_load) begin
                  lane_q      <= '0;
                  row_q       <= '0;
                  load_done_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= LOAD;
               end
            end
            default: begin
               in_ready_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign row_valid = row_valid_q;
   assign row_addr  = row_addr_q;
   assign row_data  = row_data_q;
   assign load_done = load_done_q;
   assign fft_start = fft_start_q;

endmodule
